// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared encodings for the dma_seq address/word sequencer
// Mode encodings, FSM state type and the address stepping helper.
package dma_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    MODE_WC_DOWN  = 2'b00,
    MODE_WC_UP    = 2'b01,
    MODE_ADDR_CMP = 2'b10,
    MODE_FREE     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    ACTIVE = 2'b10,
    FINISH = 2'b11
  } state_t;

  function automatic logic [CNT_W-1:0] next_addr(
    input logic [CNT_W-1:0] addr,
    input logic [CNT_W-1:0] step,
    input logic             dec
  );
    return dec ? addr - step : addr + step;
  endfunction

endpackage

// File: rtl/dma_seq_done_gen.sv
// rtl/dma_seq_done_gen.sv - terminal-beat detector for dma_seq
// Evaluated on the pre-update counters, so a true result marks the current beat as the last.
module done_gen
  import dma_pkg::*;
(
  input  mode_t            mode,
  input  logic             wci,
  input  logic [CNT_W-1:0] wc,
  input  logic [CNT_W-1:0] addr,
  input  logic [CNT_W-1:0] word,
  output logic             last
);

  always_comb begin
    last = 1'b0;
    case (mode)
      // wci selects whether the count reaching zero is itself a beat
      MODE_WC_DOWN:  last = wci ? (wc == '0) : (wc == CNT_W'(1));
      MODE_WC_UP:    last = (wc == word);
      MODE_ADDR_CMP: last = (addr == wc);
      MODE_FREE:     last = 1'b0;
      default:       last = 1'b0;
    endcase
  end

endmodule

// File: rtl/dma_seq.sv
// rtl/dma_seq.sv - four-state DMA address/word-count sequencer
// Optional macro DMA_SEQ_AUTOINIT_EN adds auto_reinit to restart a burst straight from FINISH.
module dma_seq
  import dma_pkg::*;
#(
  parameter int ADDR_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             wci,
  input  logic             dir,
  input  logic [CNT_W-1:0] addr_init,
  input  logic [CNT_W-1:0] wc_init,
  input  logic             beat_req,
  input  logic             abort,
`ifdef DMA_SEQ_AUTOINIT_EN
  input  logic             auto_reinit,
`endif
  output logic             beat_ack,
  output logic [CNT_W-1:0] addr_out,
  output logic [CNT_W-1:0] wc_out,
  output logic             busy,
  output logic             done_pulse,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(ADDR_STEP);

  state_t           state;
  mode_t            mode_q;
  logic             wci_q;
  logic             dir_q;
  logic [CNT_W-1:0] addr_q;
  logic [CNT_W-1:0] wc_q;
  logic [CNT_W-1:0] word_q;
  logic [CNT_W-1:0] addr_cfg;
  logic [CNT_W-1:0] wc_cfg;
  logic             last;

  done_gen u_done_gen (
    .mode (mode_q),
    .wci  (wci_q),
    .wc   (wc_q),
    .addr (addr_q),
    .word (word_q),
    .last (last)
  );

  // Abort has priority: a beat requested in the abort cycle is never acknowledged.
  assign beat_ack = (state == ACTIVE) & beat_req & ~abort;
  assign addr_out = addr_q;
  assign wc_out   = wc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= MODE_WC_DOWN;
      wci_q      <= 1'b0;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      wc_q       <= '0;
      word_q     <= '0;
      addr_cfg   <= '0;
      wc_cfg     <= '0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      aborted    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            mode_q   <= mode_t'(mode);
            wci_q    <= wci;
            dir_q    <= dir;
            addr_cfg <= addr_init;
            wc_cfg   <= wc_init;
          end
        end
        LOAD: begin
          // Loads come from the copies taken at start so an auto restart replays the same burst.
          addr_q <= addr_cfg;
          word_q <= wc_cfg;
          wc_q   <= (mode_q == MODE_WC_UP) ? '0 : wc_cfg;
          state  <= ACTIVE;
        end
        ACTIVE: begin
          if (abort) begin
            state   <= FINISH;
            aborted <= 1'b1;
          end else if (beat_req) begin
            addr_q <= next_addr(addr_q, STEP, dir_q);
            case (mode_q)
              MODE_WC_DOWN:  wc_q <= wc_q - CNT_W'(1);
              MODE_WC_UP:    wc_q <= wc_q + CNT_W'(1);
              MODE_FREE:     wc_q <= wc_q + CNT_W'(1);
              default:       wc_q <= wc_q;
            endcase
            if (last) begin
              state      <= FINISH;
              done_pulse <= 1'b1;
            end
          end
        end
        FINISH: begin
`ifdef DMA_SEQ_AUTOINIT_EN
          // done_pulse is only high here after a normal completion, never after an abort.
          if (done_pulse && auto_reinit) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_seq.sv
// tb/tb_dma_seq.sv - self-checking bench for dma_seq against a closed-form beat model
// Connects auto_reinit and runs the restart burst when DMA_SEQ_AUTOINIT_EN is defined.
module tb_dma_seq;

  localparam int STEP = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic       wci;
  logic       dir;
  logic [3:0] addr_init;
  logic [3:0] wc_init;
  logic       beat_req;
  logic       abort;
  logic       beat_ack;
  logic [3:0] addr_out;
  logic [3:0] wc_out;
  logic       busy;
  logic       done_pulse;
  logic       aborted;
`ifdef DMA_SEQ_AUTOINIT_EN
  logic       auto_reinit;
`endif

  int vectors = 0;
  int miscompares = 0;

  dma_seq #(.ADDR_STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .wci        (wci),
    .dir        (dir),
    .addr_init  (addr_init),
    .wc_init    (wc_init),
    .beat_req   (beat_req),
    .abort      (abort),
`ifdef DMA_SEQ_AUTOINIT_EN
    .auto_reinit(auto_reinit),
`endif
    .beat_ack   (beat_ack),
    .addr_out   (addr_out),
    .wc_out     (wc_out),
    .busy       (busy),
    .done_pulse (done_pulse),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address expected on beat i (0-based), wrapping modulo 16.
  function automatic logic [3:0] exp_addr(input logic [3:0] a, input logic d, input int i);
    int v;
    v = d ? int'(a) - i * STEP : int'(a) + i * STEP;
    return v[3:0];
  endfunction

  function automatic logic [3:0] exp_wc(input logic [1:0] m, input logic [3:0] w, input int i);
    int v;
    case (m)
      2'b00:   v = int'(w) - i;
      2'b01:   v = i;
      2'b10:   v = int'(w);
      default: v = int'(w) + i;
    endcase
    return v[3:0];
  endfunction

  // Number of beats a transfer makes before completing; 1000 means it never completes.
  function automatic int n_beats(input logic [1:0] m, input logic c, input logic d,
                                 input logic [3:0] a, input logic [3:0] w);
    case (m)
      2'b00: return c ? int'(w) + 1 : (w == 4'd0 ? 16 : int'(w));
      2'b01: return int'(w) + 1;
      2'b10: begin
        for (int k = 0; k < 16; k++) if (exp_addr(a, d, k) == w) return k + 1;
        return 1000;
      end
      default: return 1000;
    endcase
  endfunction

  task automatic issue_start(input logic [1:0] m, input logic c, input logic d,
                             input logic [3:0] a, input logic [3:0] w);
    @(negedge clk);
    mode = m; wci = c; dir = d; addr_init = a; wc_init = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); wci = 1'($urandom); dir = 1'($urandom);
    addr_init = 4'($urandom); wc_init = 4'($urandom);
  endtask

  // Entered at the negedge where the DUT sits in LOAD.
  task automatic run_body(input logic [1:0] m, input logic c, input logic d,
                          input logic [3:0] a, input logic [3:0] w,
                          input int abort_at, input bit hold, input bit reinit);
    int  n, i;
    bit  fin, ab;
    n = n_beats(m, c, d, a, w);
    i = 0; fin = 0; ab = 0;
    beat_req = hold;
    #1;
    chk("load_busy", busy, 1);
    chk("load_ack", beat_ack, 0);
    @(negedge clk);
    chk("init_addr", addr_out, exp_addr(a, d, 0));
    chk("init_wc", wc_out, exp_wc(m, w, 0));
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      beat_req = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      abort    = (i == abort_at);
      start    = ($urandom_range(0, 5) == 0);
      #1;
      chk("beat_ack", beat_ack, beat_req & ~abort);
      if (abort) begin
        fin = 1; ab = 1;
      end else if (beat_req) begin
        chk("beat_addr", addr_out, exp_addr(a, d, i));
        chk("beat_wc", wc_out, exp_wc(m, w, i));
        i++;
        if (i == n) fin = 1;
      end
      @(negedge clk);
      beat_req = 1'b0; abort = 1'b0; start = 1'b0;
    end
    if (!fin) chk("timeout", 0, 1);
    chk("fin_done", done_pulse, !ab);
    chk("fin_aborted", aborted, ab);
    chk("fin_busy", busy, 1);
    abort = 1'($urandom); beat_req = 1'b1;
    #1;
    chk("fin_ack", beat_ack, 0);
    @(negedge clk);
    abort = 1'b0; beat_req = 1'b0;
    if (reinit) begin
      chk("reload_busy", busy, 1);
      chk("reload_done", done_pulse, 0);
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done_pulse, 0);
      chk("idle_aborted", aborted, 0);
      chk("held_addr", addr_out, exp_addr(a, d, i));
      chk("held_wc", wc_out, exp_wc(m, w, i));
      beat_req = 1'b1; abort = 1'b1;
      #1;
      chk("idle_ack", beat_ack, 0);
      @(negedge clk);
      beat_req = 1'b0; abort = 1'b0;
      chk("idle_stay_busy", busy, 0);
      chk("idle_stay_addr", addr_out, exp_addr(a, d, i));
    end
  endtask

  initial begin
    logic [1:0] m;
    logic       c, d;
    logic [3:0] a, w;
    int         n, ab_at;

    rst_n = 1'b0; start = 1'b0; mode = 2'b00; wci = 1'b0; dir = 1'b0;
    addr_init = 4'd0; wc_init = 4'd0; beat_req = 1'b0; abort = 1'b0;
`ifdef DMA_SEQ_AUTOINIT_EN
    auto_reinit = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_wc", wc_out, 0);
    chk("rst_ack", beat_ack, 0);
    rst_n = 1'b1;

    // Directed bursts: count-down, count-up with decrement, address compare across wrap.
    issue_start(2'b00, 1'b0, 1'b0, 4'h4, 4'h3);
    run_body(2'b00, 1'b0, 1'b0, 4'h4, 4'h3, -1, 1'b1, 1'b0);
    issue_start(2'b01, 1'b0, 1'b1, 4'h0, 4'h2);
    run_body(2'b01, 1'b0, 1'b1, 4'h0, 4'h2, -1, 1'b1, 1'b0);
    issue_start(2'b10, 1'b0, 1'b0, 4'hE, 4'h1);
    run_body(2'b10, 1'b0, 1'b0, 4'hE, 4'h1, -1, 1'b1, 1'b0);
    issue_start(2'b00, 1'b0, 1'b0, 4'h9, 4'h0);
    run_body(2'b00, 1'b0, 1'b0, 4'h9, 4'h0, -1, 1'b1, 1'b0);
    issue_start(2'b00, 1'b0, 1'b1, 4'h2, 4'h1);
    run_body(2'b00, 1'b0, 1'b1, 4'h2, 4'h1, -1, 1'b0, 1'b0);
    issue_start(2'b00, 1'b1, 1'b0, 4'h5, 4'h0);
    run_body(2'b00, 1'b1, 1'b0, 4'h5, 4'h0, -1, 1'b0, 1'b0);
    // Free-run aborted together with the 5th beat request.
    issue_start(2'b11, 1'b0, 1'b0, 4'h3, 4'h6);
    run_body(2'b11, 1'b0, 1'b0, 4'h3, 4'h6, 4, 1'b1, 1'b0);

    // Reset in the middle of a transfer.
    issue_start(2'b11, 1'b0, 1'b0, 4'h7, 4'h2);
    @(negedge clk);
    beat_req = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done_pulse, 0);
    chk("mid_rst_aborted", aborted, 0);
    chk("mid_rst_addr", addr_out, 0);
    chk("mid_rst_wc", wc_out, 0);
    chk("mid_rst_ack", beat_ack, 0);
    @(negedge clk);
    rst_n = 1'b1; beat_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_pulse", done_pulse | aborted, 0);
    end

`ifdef DMA_SEQ_AUTOINIT_EN
    auto_reinit = 1'b1;
    issue_start(2'b00, 1'b0, 1'b0, 4'h4, 4'h3);
    run_body(2'b00, 1'b0, 1'b0, 4'h4, 4'h3, -1, 1'b1, 1'b1);
    auto_reinit = 1'b0;
    run_body(2'b00, 1'b0, 1'b0, 4'h4, 4'h3, -1, 1'b0, 1'b0);
`endif

    // Randomized transfers with stalls, stray starts and occasional aborts.
    for (int t = 0; t < 40; t++) begin
      m = 2'($urandom); c = 1'($urandom); d = 1'($urandom);
      a = 4'($urandom); w = 4'($urandom);
      n = n_beats(m, c, d, a, w);
      if (n >= 1000) ab_at = $urandom_range(0, 20);
      else if ($urandom_range(0, 3) == 0) ab_at = $urandom_range(0, n - 1);
      else ab_at = -1;
      issue_start(m, c, d, a, w);
      run_body(m, c, d, a, w, ab_at, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_seq.md
DMA_SEQ -- requirements
Module: dma_seq

Interface
REQ-001 The module SHALL have the parameter ADDR_STEP, default 1, meaning the address counter increment/decrement per beat (1..15, modulo 16).
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 Port mode  input  2  transfer mode, captured at start: 00 word-count down, 01 word-count up to compare, 10 address compare, 11 free-run.
REQ-006 Port wci  input  1  word-count carry-in select, captured at start (mode 00 only).
REQ-007 Port dir  input  1  address direction, captured at start: 0 increment, 1 decrement.
REQ-008 Port addr_init  input  4  initial address.
REQ-009 Port wc_init  input  4  initial word count (mode 00), compare value (mode 01) or stop address (mode 10).
REQ-010 Port beat_req  input  1  peripheral requests one data beat.
REQ-011 Port abort  input  1  terminate the active transfer.
REQ-012 Port beat_ack  output  1  beat accepted this cycle.
REQ-013 Port addr_out  output  4  current address counter.
REQ-014 Port wc_out  output  4  current word counter.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port done_pulse  output  1  one-cycle pulse on normal completion.
REQ-017 Port aborted  output  1  one-cycle pulse on abort completion.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, ACTIVE and FINISH.
REQ-019 IDLE->LOAD on start; LOAD SHALL load the counters and the word register for one cycle, then go to ACTIVE.
REQ-020 Load values: addr=addr_init; word register=wc_init; word counter=wc_init in modes 00/10, 0 in mode 01, wc_init in mode 11.
REQ-021 In ACTIVE, beat_ack=beat_req & ~abort, combinationally; counters SHALL update on the ack edge only.
REQ-022 Per acked beat: addr +/- ADDR_STEP modulo 16; word counter -1 in mode 00, +1 in modes 01/11, held in mode 10; all wrap modulo 16.
REQ-023 Terminal test on pre-update values: 00&wci=0: wc==1; 00&wci=1: wc==0; 01: wc==word register; 10: addr==wc; 11: never.
REQ-024 An acked beat with the terminal test true SHALL be the last beat: ACTIVE->FINISH, done_pulse=1 in FINISH, then IDLE.
REQ-025 Beat counts: mode 00/wci=0 with wc_init=0 gives 16 beats (0,F..1); wc_init=1 gives 1 beat; mode 01 gives wc_init+1 beats.
REQ-026 Abort in ACTIVE SHALL win over beat_req (no ack); ->FINISH with aborted=1 and done_pulse=0; abort is ignored in IDLE, LOAD and FINISH.
REQ-027 start while busy SHALL be ignored; the counters SHALL hold their final values in IDLE until the next LOAD.

Reset
REQ-028 On rst_n low: state=IDLE; counters, word register and captured mode/wci/dir=0; beat_ack, busy, done_pulse, aborted=0.
REQ-029 Reset mid-transfer SHALL discard the transfer with no completion pulse.

Configuration
REQ-030 Macro DMA_SEQ_AUTOINIT_EN: when defined, add input auto_reinit (1 bit); on normal completion with auto_reinit=1, FINISH SHALL pulse done_pulse and go to LOAD, reloading from the stored addr_init/wc_init copies captured at the original start.
REQ-031 When DMA_SEQ_AUTOINIT_EN is undefined, the port SHALL be absent and FINISH SHALL always go to IDLE.

Structure
REQ-032 The package dma_pkg SHALL hold the mode encodings (MODE_WC_DOWN, MODE_WC_UP, MODE_ADDR_CMP, MODE_FREE) and the FSM state typedef.
REQ-033 The terminal test SHALL be the existing done_gen instantiated as the sole sub-module, fed by the counters, the word register, the captured wci and the captured mode.

Verification
REQ-034 Mode 00, wci=0, addr_init=4, wc_init=3, beat_req held high -> 3 acks, addr 4,5,6, done_pulse one cycle after the third ack.
REQ-035 Mode 01, wc_init=2, dir=1, addr_init=0 -> 3 acks, addr 0,F,E, wc 0,1,2, done_pulse.
REQ-036 Mode 10, addr_init=E, wc_init=1 -> acks at addr E,F,0,1 (wrap), then done_pulse.
REQ-037 Mode 11, abort and beat_req asserted together on the 5th beat -> no ack on that cycle, aborted=1, done_pulse=0, busy low 2 cycles later.
REQ-038 start during ACTIVE and rst_n low mid-transfer -> the start is ignored; reset clears all outputs with no pulse.
REQ-039 With DMA_SEQ_AUTOINIT_EN defined and auto_reinit=1 -> a second identical burst follows without passing through IDLE.
